// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle controller: states, instruction
// classes, immediate/ALU encodings and opcode match patterns.
package multicycle_controller_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ILL = 3'd0,
      C_R   = 3'd1,
      C_I   = 3'd2,
      C_LD  = 3'd3,
      C_ST  = 3'd4,
      C_B   = 3'd5,
      C_CBZ = 3'd6
   } iclass_t;

   localparam logic [1:0] IMM_B  = 2'b00;
   localparam logic [1:0] IMM_CB = 2'b01;
   localparam logic [1:0] IMM_I  = 2'b10;
   localparam logic [1:0] IMM_D  = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   // Class plus the ALU operation it needs in EXEC, captured together in DECODE.
   typedef struct packed {
      iclass_t    cls;
      logic [1:0] alu_op;
   } decoded_t;

   // A mask bit of 0 marks a don't-care opcode bit.
   localparam logic [10:0] OP_ADD  = 11'b10001011000, MSK_ADD  = 11'b11111111111;
   localparam logic [10:0] OP_SUB  = 11'b11001011000, MSK_SUB  = 11'b11111111111;
   localparam logic [10:0] OP_AND  = 11'b10001010000, MSK_AND  = 11'b11111111111;
   localparam logic [10:0] OP_ORR  = 11'b10101010000, MSK_ORR  = 11'b11111111111;
   localparam logic [10:0] OP_ADDI = 11'b10010001000, MSK_ADDI = 11'b11111111110;
   localparam logic [10:0] OP_SUBI = 11'b11010001000, MSK_SUBI = 11'b11111111110;
   localparam logic [10:0] OP_LD   = 11'b11111000010, MSK_LD   = 11'b11111111111;
   localparam logic [10:0] OP_ST   = 11'b11111000000, MSK_ST   = 11'b11111111111;
   localparam logic [10:0] OP_B    = 11'b00010100000, MSK_B    = 11'b11111100000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000, MSK_CBZ  = 11'b11111111000;

   function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                     input logic [10:0] msk);
      return ((op ^ pat) & msk) == 11'd0;
   endfunction

   function automatic logic [1:0] imm_for(input iclass_t cls);
      case (cls)
         C_CBZ:      return IMM_CB;
         C_I:        return IMM_I;
         C_LD, C_ST: return IMM_D;
         default:    return IMM_B;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_classify.sv
// Combinational opcode decoder: maps instruction[31:21] to an instruction class
// and the ALU operation that class uses.
module opcode_classify
   import multicycle_controller_pkg::*;
(
   input  logic [10:0] opcode,
   output decoded_t    dec
);

   always_comb begin
      dec.cls    = C_ILL;
      dec.alu_op = ALU_ADD;
      if (op_match(opcode, OP_ADD, MSK_ADD)) begin
         dec.cls = C_R;
      end else if (op_match(opcode, OP_SUB, MSK_SUB)) begin
         dec.cls    = C_R;
         dec.alu_op = ALU_SUB;
      end else if (op_match(opcode, OP_AND, MSK_AND)) begin
         dec.cls    = C_R;
         dec.alu_op = ALU_AND;
      end else if (op_match(opcode, OP_ORR, MSK_ORR)) begin
         dec.cls    = C_R;
         dec.alu_op = ALU_ORR;
      end else if (op_match(opcode, OP_ADDI, MSK_ADDI)) begin
         dec.cls = C_I;
      end else if (op_match(opcode, OP_SUBI, MSK_SUBI)) begin
         dec.cls    = C_I;
         dec.alu_op = ALU_SUB;
      end else if (op_match(opcode, OP_LD, MSK_LD)) begin
         dec.cls = C_LD;
      end else if (op_match(opcode, OP_ST, MSK_ST)) begin
         dec.cls = C_ST;
      end else if (op_match(opcode, OP_B, MSK_B)) begin
         dec.cls = C_B;
      end else if (op_match(opcode, OP_CBZ, MSK_CBZ)) begin
         dec.cls = C_CBZ;
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath controller: IDLE/FETCH/DECODE/EXEC/MEM/WB FSM with a
// memory wait watchdog. Memory handshake: mem_req is held for the whole FETCH or
// MEM state; a cycle with mem_req=1 and mem_ready=1 completes the access.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic [10:0] opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_src,
   output logic [1:0]  imm_sel,
   output logic        alu_src,
   output logic [1:0]  alu_op,
   output logic        mem_req,
   output logic        mem_we,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        illegal,
   output logic        timeout,
   output logic [2:0]  state
);

   localparam int             CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  LAST_WAIT = CW'(TIMEOUT - 1);

   state_t          state_q, state_d;
   decoded_t        dec, dec_q;
   iclass_t         cls_now;
   logic [CW-1:0]   wait_cnt;
   logic            waiting, abort;
   logic            illegal_q, timeout_q;

   opcode_classify u_classify (
      .opcode (opcode),
      .dec    (dec)
   );

   assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
   // The wait that would make the count reach TIMEOUT aborts; mem_ready wins over it.
   assign abort   = waiting && (wait_cnt == LAST_WAIT);

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q   <= S_IDLE;
         dec_q     <= '{cls: C_ILL, alu_op: ALU_ADD};
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         if (state_q == S_DECODE) dec_q <= dec;
         wait_cnt  <= (waiting && !abort) ? wait_cnt + CW'(1) : '0;
         illegal_q <= (state_q == S_DECODE) && (dec.cls == C_ILL);
         timeout_q <= abort;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: state_d = (dec.cls == C_ILL) ? S_FETCH : S_EXEC;
         S_EXEC: begin
            case (dec_q.cls)
               C_R, C_I:   state_d = S_WB;
               C_LD, C_ST: state_d = S_MEM;
               default:    state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem_ready)  state_d = (dec_q.cls == C_LD) ? S_WB : S_FETCH;
            else if (abort) state_d = S_FETCH;
         end
         S_WB:     state_d = S_FETCH;
         default:  state_d = S_IDLE;
      endcase
   end

   // DECODE classifies the instruction register live; later states use the captured class.
   assign cls_now = (state_q == S_DECODE) ? dec.cls : dec_q.cls;

   always_comb begin
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_src  = 1'b0;
      imm_sel = IMM_B;
      alu_src = 1'b0;
      alu_op  = ALU_ADD;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      reg_we  = 1'b0;
      wb_sel  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ready;
            pc_we   = mem_ready;
         end
         S_DECODE: imm_sel = imm_for(cls_now);
         S_EXEC: begin
            imm_sel = imm_for(cls_now);
            alu_src = (cls_now == C_I) || (cls_now == C_LD) || (cls_now == C_ST);
            alu_op  = dec_q.alu_op;
            if (cls_now == C_B) begin
               pc_we  = 1'b1;
               pc_src = 1'b1;
            end else if (cls_now == C_CBZ) begin
               pc_we  = zero;
               pc_src = zero;
            end
         end
         S_MEM: begin
            imm_sel = imm_for(cls_now);
            mem_req = 1'b1;
            mem_we  = (cls_now == C_ST);
         end
         S_WB: begin
            imm_sel = imm_for(cls_now);
            reg_we  = 1'b1;
            wb_sel  = (cls_now == C_LD);
         end
         default: ;
      endcase
   end

   assign illegal = illegal_q;
   assign timeout = timeout_q;
   assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table for each
// instruction class, plus hand sequences for timeouts and reset during MEM.
module tb_multicycle_controller;

   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                          S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_ADDI = 11'b10010001000;
   localparam logic [10:0] OP_SUBI = 11'b11010001001;
   localparam logic [10:0] OP_LD   = 11'b11111000010;
   localparam logic [10:0] OP_ST   = 11'b11111000000;
   localparam logic [10:0] OP_B    = 11'b00010111111;
   localparam logic [10:0] OP_CBZ  = 11'b10110100011;
   localparam logic [10:0] OP_ILL  = 11'b11111111111;

   localparam logic [13:0] ALL      = 14'h3fff;
   localparam logic [13:0] CARE_DEC = 14'h3fff & ~14'h0600;

   logic        CLK = 1'b0;
   logic        resetl = 1'b0;
   logic [10:0] opcode = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        ir_we, pc_we, pc_src, alu_src, mem_req, mem_we, reg_we, wb_sel;
   logic        illegal, timeout;
   logic [1:0]  imm_sel, alu_op;
   logic [2:0]  state;
   logic [13:0] outs;

   typedef struct {
      logic [10:0] op;
      logic        z;
      logic        rdy;
      logic [2:0]  st;
      logic [13:0] out;
      logic [13:0] care;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   logic [13:0] fr, fw, mw_ld;

   always #5 CLK = ~CLK;

   multicycle_controller #(.TIMEOUT(15)) dut (
      .CLK       (CLK),
      .resetl    (resetl),
      .opcode    (opcode),
      .zero      (zero),
      .mem_ready (mem_ready),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .pc_src    (pc_src),
      .imm_sel   (imm_sel),
      .alu_src   (alu_src),
      .alu_op    (alu_op),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .reg_we    (reg_we),
      .wb_sel    (wb_sel),
      .illegal   (illegal),
      .timeout   (timeout),
      .state     (state)
   );

   assign outs = {ir_we, pc_we, pc_src, imm_sel, alu_src, alu_op,
                  mem_req, mem_we, reg_we, wb_sel, illegal, timeout};

   function automatic logic [13:0] o(input logic ir, pc, pcs, input logic [1:0] imm,
                                     input logic asrc, input logic [1:0] aop,
                                     input logic mreq, mwe, rwe, wbs, ill, to);
      return {ir, pc, pcs, imm, asrc, aop, mreq, mwe, rwe, wbs, ill, to};
   endfunction

   task automatic check(input string nm, input logic [2:0] st, input logic [13:0] out,
                        input logic [13:0] care);
      checks++;
      if (state !== st || ((outs ^ out) & care) !== 14'd0) begin
         errors++;
         $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b care=%b",
                  nm, state, outs, st, out, care);
      end
   endtask

   task automatic step(input string nm, input logic [10:0] op, input logic z, rdy,
                       input logic [2:0] st, input logic [13:0] out, input logic [13:0] care);
      opcode    = op;
      zero      = z;
      mem_ready = rdy;
      #1;
      check(nm, st, out, care);
      @(negedge CLK);
   endtask

   task automatic add_vec(input logic [10:0] op, input logic z, rdy, input logic [2:0] st,
                          input logic [13:0] out, input logic [13:0] care);
      vecs.push_back('{op, z, rdy, st, out, care});
   endtask

   task automatic add_fd(input logic [10:0] op, input logic z);
      add_vec(op, z, 1'b1, S_FETCH, fr, ALL);
      add_vec(op, z, 1'b0, S_DECODE, 14'd0, CARE_DEC);
   endtask

   task automatic add_alu(input logic [10:0] op, input logic [1:0] imm, input logic asrc,
                          input logic [1:0] aop);
      add_fd(op, 1'b0);
      add_vec(op, 1'b0, 1'b0, S_EXEC, o(0,0,0,imm,asrc,aop,0,0,0,0,0,0), ALL);
      add_vec(op, 1'b0, 1'b0, S_WB,   o(0,0,0,imm,0,2'b00,0,0,1,0,0,0), ALL);
   endtask

   initial begin
      fr    = o(1,1,0,2'b00,0,2'b00,1,0,0,0,0,0);
      fw    = o(0,0,0,2'b00,0,2'b00,1,0,0,0,0,0);
      mw_ld = o(0,0,0,2'b11,0,2'b00,1,0,0,0,0,0);

      add_vec(OP_ADD, 0, 0, S_IDLE, 14'd0, ALL);
      add_alu(OP_ADD,  2'b00, 0, 2'b00);
      add_alu(OP_SUB,  2'b00, 0, 2'b01);
      add_alu(OP_AND,  2'b00, 0, 2'b10);
      add_alu(OP_ORR,  2'b00, 0, 2'b11);
      add_alu(OP_ADDI, 2'b10, 1, 2'b00);
      add_alu(OP_SUBI, 2'b10, 1, 2'b01);
      // LDUR with three not-ready cycles in MEM
      add_fd(OP_LD, 0);
      add_vec(OP_LD, 0, 0, S_EXEC, o(0,0,0,2'b11,1,2'b00,0,0,0,0,0,0), ALL);
      for (int i = 0; i < 3; i++) add_vec(OP_LD, 0, 0, S_MEM, mw_ld, ALL);
      add_vec(OP_LD, 0, 1, S_MEM, mw_ld, ALL);
      add_vec(OP_LD, 0, 0, S_WB, o(0,0,0,2'b11,0,2'b00,0,0,1,1,0,0), ALL);
      add_fd(OP_ST, 0);
      add_vec(OP_ST, 0, 0, S_EXEC, o(0,0,0,2'b11,1,2'b00,0,0,0,0,0,0), ALL);
      add_vec(OP_ST, 0, 1, S_MEM,  o(0,0,0,2'b11,0,2'b00,1,1,0,0,0,0), ALL);
      add_fd(OP_B, 0);
      add_vec(OP_B, 0, 0, S_EXEC, o(0,1,1,2'b00,0,2'b00,0,0,0,0,0,0), ALL);
      add_fd(OP_CBZ, 1);
      add_vec(OP_CBZ, 1, 0, S_EXEC, o(0,1,1,2'b01,0,2'b00,0,0,0,0,0,0), ALL);
      add_fd(OP_CBZ, 0);
      add_vec(OP_CBZ, 0, 0, S_EXEC, o(0,0,0,2'b01,0,2'b00,0,0,0,0,0,0), ALL);
      add_fd(OP_ILL, 0);
      add_vec(OP_ILL, 0, 0, S_FETCH, o(0,0,0,2'b00,0,2'b00,1,0,0,0,1,0), ALL);
      add_alu(OP_ADD, 2'b00, 0, 2'b00);

      // Reset state
      @(negedge CLK);
      #1 check("reset_a", S_IDLE, 14'd0, ALL);
      @(negedge CLK);
      #1 check("reset_b", S_IDLE, 14'd0, ALL);
      @(negedge CLK);
      resetl = 1'b1;

      foreach (vecs[i])
         step($sformatf("vec%0d", i), vecs[i].op, vecs[i].z, vecs[i].rdy,
              vecs[i].st, vecs[i].out, vecs[i].care);

      // FETCH watchdog: 15 silent cycles abort, the 15th cycle with ready completes
      for (int i = 1; i <= 15; i++) step($sformatf("fwait%0d", i), OP_LD, 0, 0, S_FETCH, fw, ALL);
      step("fetch_timeout", OP_LD, 0, 0, S_FETCH, o(0,0,0,2'b00,0,2'b00,1,0,0,0,0,1), ALL);
      for (int i = 2; i <= 14; i++) step($sformatf("fwait2_%0d", i), OP_LD, 0, 0, S_FETCH, fw, ALL);
      step("fetch_ready15", OP_LD, 0, 1, S_FETCH, fr, ALL);
      step("fetch_ready15_dec", OP_LD, 0, 0, S_DECODE, 14'd0, CARE_DEC);
      step("ld_exec", OP_LD, 0, 0, S_EXEC, o(0,0,0,2'b11,1,2'b00,0,0,0,0,0,0), ALL);

      // MEM watchdog: abort goes to FETCH without a register write
      for (int i = 1; i <= 15; i++) step($sformatf("mwait%0d", i), OP_LD, 0, 0, S_MEM, mw_ld, ALL);
      step("mem_timeout", OP_ST, 0, 0, S_FETCH, o(0,0,0,2'b00,0,2'b00,1,0,0,0,0,1), ALL);
      step("st_fetch", OP_ST, 0, 1, S_FETCH, fr, ALL);
      step("st_dec", OP_ST, 0, 0, S_DECODE, 14'd0, CARE_DEC);
      step("st_exec", OP_ST, 0, 0, S_EXEC, o(0,0,0,2'b11,1,2'b00,0,0,0,0,0,0), ALL);

      // Reset asserted mid-MEM of STUR
      mem_ready = 1'b0;
      #1 check("st_mem_we", S_MEM, o(0,0,0,2'b11,0,2'b00,1,1,0,0,0,0), ALL);
      #1 resetl = 1'b0;
      #1 check("async_reset", S_IDLE, 14'd0, ALL);
      @(negedge CLK);
      resetl = 1'b1;
      step("post_reset_idle", OP_ADD, 0, 0, S_IDLE, 14'd0, ALL);
      step("post_reset_fetch", OP_ADD, 0, 0, S_FETCH, fw, ALL);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
